mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Parametrised successor to the team's multicycle MIPS control FSM.
- Clocked Moore FSM that sequences fetch/decode/execute/memory/writeback for R-type, I-type ALU, load/store (word/half/byte), beq/bne/bgtz and j.
- Adds a memory ready handshake with wait states, a wait-timeout error state, a branch-type output, and an optional illegal-opcode trap.
- Sits between the instruction register and the datapath muxes, ALU control, register file and memory.

Parameters:
INSTR_W, 32, instruction width; the opcode is always instr[INSTR_W-1 -: 6]
WAIT_MAX, 15, maximum consecutive cycles a memory state may wait for mem_ready before erroring (1..255)
WCNT_W, 8, wait-counter width; must satisfy 2^WCNT_W > WAIT_MAX

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr  in  INSTR_W  current instruction (IR output)
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load qualified by the branch result in the datapath
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
mem_to_reg  out  1  register write-data select: 1 = MDR
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2
alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct decode, 11 = opcode decode (immediate)
pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector
branch_type  out  2  00 = beq, 01 = bne, 10 = bgtz; valid while pc_write_cond = 1
mem_size  out  2  00 = word, 01 = half, 10 = byte
state  out  4  current state code, for debug
mem_err  out  1  sticky memory-timeout flag
exc_illegal  out  1  one-cycle illegal-opcode pulse (optional feature only)

Behaviour:
- Reset: the state register goes to FETCH(0) on the rising edge with rst = 1.
  - Wait counter = 0, mem_err = 0.
  - All outputs are decoded from the state, so FETCH values appear on reset.
- Outputs are pure functions of state, plus ir_write/pc_write gated by mem_ready in FETCH. Outputs not listed for a state are 0. No X is ever driven.
- State codes:
  - 0 FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
    - ir_write = pc_write = mem_ready.
    - Moves to DECODE when mem_ready = 1, else stays.
  - 1 DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00. Next state by opcode:
    - 000000 -> EXEC_R.
    - 100011/100001/100000/101011/101001/101000 -> MEM_ADDR.
    - 001000/001100/001101/001010 -> EXEC_I.
    - 000100/000101/000111 -> BRANCH.
    - 000010 -> JUMP.
    - Any other opcode -> FETCH (treated as a NOP).
  - 2 MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Loads -> MEM_RD; stores -> MEM_WR.
  - 3 MEM_RD: mem_read = 1, iord = 1, mem_size from opcode. Moves to MEM_WB on mem_ready.
  - 4 MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0 -> FETCH.
  - 5 MEM_WR: mem_write = 1, iord = 1, mem_size from opcode. Moves to FETCH on mem_ready.
  - 6 EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> ALU_WB.
  - 7 ALU_WB: reg_write = 1, reg_dst = 1 -> FETCH.
  - 8 BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, branch_type from opcode -> FETCH.
  - 9 JUMP: pc_write = 1, pc_source = 10 -> FETCH.
  - 10 EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 11 -> IMM_WB.
  - 11 IMM_WB: reg_write = 1, reg_dst = 0 -> FETCH.
  - 12 TRAP: used by the optional feature only.
  - 15 ERR: all strobes 0. Terminal; only rst leaves it.
- mem_size: lw/sw = 00, lh/sh = 01, lb/sb = 10.
- Wait counter: active in FETCH, MEM_RD and MEM_WR.
  - Increments each cycle mem_ready = 0; clears on mem_ready = 1 or on leaving the state.
  - When the counter equals WAIT_MAX and mem_ready = 0, the next state is ERR and mem_err is set.
  - If mem_ready = 1 arrives in that same cycle, the normal transition wins.
- Latency with mem_ready tied to 1:
  - R-type 4 cycles; I-type ALU 4; load 5; store 4; branch 3; jump 3.
  - Each wait cycle adds 1.
- rst mid-instruction: abandons the instruction immediately; no strobe is asserted in the reset cycle's next state except the FETCH set.

Optional Feature:
MIPS_CTRL_ILLEGAL_TRAP_EN
- Defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP drives pc_write = 1, pc_source = 11, exc_illegal = 1 for one cycle, then goes to FETCH.
- Undefined:
  - An unknown opcode goes DECODE -> FETCH.
  - exc_illegal is tied to 0 and state 12 is unreachable.

Test Plan:
- Reset, then lw (0x8C220004) with mem_ready = 1: states 0,1,2,3,4,0. In state 4, reg_write = 1, mem_to_reg = 1, mem_size = 00.
- add (opcode 000000) with mem_ready = 1: states 0,1,6,7,0. alu_op = 10 in state 6; reg_dst = 1, reg_write = 1 in state 7.
- bne (000101): state 8 shows pc_write_cond = 1, branch_type = 01, alu_op = 01, pc_source = 01. j (000010): state 9 shows pc_write = 1, pc_source = 10.
- sb (101000) with mem_ready low 3 cycles in MEM_WR: mem_write held for 4 cycles, mem_size = 10, then FETCH.
- mem_ready held 0 in FETCH with WAIT_MAX = 15: after 16 cycles state = 15 and mem_err = 1, held until rst; rst returns state to 0 and mem_err to 0.
- Opcode 111111: without the macro, DECODE -> FETCH; with MIPS_CTRL_ILLEGAL_TRAP_EN, state 12 with exc_illegal = 1 and pc_source = 11 for one cycle, then FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// with a mem_ready handshake, a wait-state timeout into a sticky error state,
// branch-type and access-size outputs for the datapath.
// Optional feature: define MIPS_CTRL_ILLEGAL_TRAP_EN to send unknown opcodes
// through the TRAP state (exception vector load plus exc_illegal pulse).
module mips_multicycle_ctrl #(
    parameter int INSTR_W  = 32,
    parameter int WAIT_MAX = 15,
    parameter int WCNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [1:0]         branch_type,
    output logic [1:0]         mem_size,
    output logic [3:0]         state,
    output logic               mem_err,
    output logic               exc_illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_IMM_WB   = 4'd11,
        S_TRAP     = 4'd12,
        S_ERR      = 4'd15
    } state_t;

    state_t            state_q;
    state_t            state_next;
    logic [WCNT_W-1:0] wait_cnt;
    logic [5:0]        opcode;
    logic              instr_unused;
    logic              is_rtype, is_load, is_store, is_imm, is_branch, is_jump;
    logic [1:0]        size_sel;
    logic [1:0]        btype_sel;
    logic              wait_active;
    logic              timeout;

    // Only the opcode field steers control; the rest of the word is ignored.
    assign opcode       = instr[INSTR_W-1 -: 6];
    assign instr_unused = ^instr[INSTR_W-7:0];
    assign state        = state_q;

    assign wait_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout     = wait_active && !mem_ready && (wait_cnt == WCNT_W'(WAIT_MAX));

    // Classify the opcode and derive access size and branch flavour.
    always_comb begin
        is_rtype  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_imm    = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        size_sel  = 2'b00;
        btype_sel = 2'b00;
        case (opcode)
            6'b000000: is_rtype = 1'b1;
            6'b100011: is_load  = 1'b1;
            6'b100001: begin is_load  = 1'b1; size_sel = 2'b01; end
            6'b100000: begin is_load  = 1'b1; size_sel = 2'b10; end
            6'b101011: is_store = 1'b1;
            6'b101001: begin is_store = 1'b1; size_sel = 2'b01; end
            6'b101000: begin is_store = 1'b1; size_sel = 2'b10; end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: is_imm = 1'b1;
            6'b000100: is_branch = 1'b1;
            6'b000101: begin is_branch = 1'b1; btype_sel = 2'b01; end
            6'b000111: begin is_branch = 1'b1; btype_sel = 2'b10; end
            6'b000010: is_jump = 1'b1;
            default: ;
        endcase
    end

    // Next-state logic; a memory wait that hits its limit overrides everything.
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (is_rtype)                 state_next = S_EXEC_R;
                else if (is_load || is_store) state_next = S_MEM_ADDR;
                else if (is_imm)              state_next = S_EXEC_I;
                else if (is_branch)           state_next = S_BRANCH;
                else if (is_jump)             state_next = S_JUMP;
                else
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                                              state_next = S_TRAP;
`else
                                              state_next = S_FETCH;
`endif
            end
            S_MEM_ADDR: state_next = is_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WB:   state_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_EXEC_R:   state_next = S_ALU_WB;
            S_ALU_WB:   state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_EXEC_I:   state_next = S_IMM_WB;
            S_IMM_WB:   state_next = S_FETCH;
            S_TRAP:     state_next = S_FETCH;
            S_ERR:      state_next = S_ERR;
            default:    state_next = S_FETCH;
        endcase
        if (timeout) state_next = S_ERR;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_next;
    end

    // Count consecutive not-ready cycles in a memory state; any exit clears it.
    always_ff @(posedge clk) begin
        if (rst)                                   wait_cnt <= '0;
        else if (wait_active && !mem_ready && !timeout) wait_cnt <= wait_cnt + WCNT_W'(1);
        else                                       wait_cnt <= '0;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)          mem_err <= 1'b0;
        else if (timeout) mem_err <= 1'b1;
    end

    // Moore output decode; FETCH additionally gates IR/PC load with mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        branch_type   = 2'b00;
        mem_size      = 2'b00;
        exc_illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            S_MEM_RD:   begin mem_read = 1'b1; iord = 1'b1; mem_size = size_sel; end
            S_MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
            S_MEM_WR:   begin mem_write = 1'b1; iord = 1'b1; mem_size = size_sel; end
            S_EXEC_R:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
            S_ALU_WB:   begin reg_write = 1'b1; reg_dst = 1'b1; end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_type   = btype_sel;
            end
            S_JUMP:     begin pc_write = 1'b1; pc_source = 2'b10; end
            S_EXEC_I:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 2'b11; end
            S_IMM_WB:   reg_write = 1'b1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     begin pc_write = 1'b1; pc_source = 2'b11; exc_illegal = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: directed instruction sequences with
// hand-derived per-cycle expectations pushed to a scoreboard queue and
// compared by an independent negedge monitor.
// Honours MIPS_CTRL_ILLEGAL_TRAP_EN when the design is built with it.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] branch_type;
        logic [1:0] mem_size;
        logic       mem_err;
        logic       exc_illegal;
    } obs_t;

    localparam logic [31:0] LW   = 32'h8C220004;
    localparam logic [31:0] ADD  = 32'h00221820;
    localparam logic [31:0] BNE  = 32'h14220003;
    localparam logic [31:0] BEQ  = 32'h10220003;
    localparam logic [31:0] BGTZ = 32'h1C200004;
    localparam logic [31:0] JMP  = 32'h08000010;
    localparam logic [31:0] ADDI = 32'h20220005;
    localparam logic [31:0] SB   = 32'hA0220001;
    localparam logic [31:0] SW   = 32'hAC220008;
    localparam logic [31:0] LH   = 32'h84220002;
    localparam logic [31:0] ILL  = 32'hFC000000;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source, branch_type, mem_size;
    logic [3:0]  state;
    logic        mem_err, exc_illegal;

    obs_t sb_q[$];
    int   vectors;
    int   miscompares;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .branch_type(branch_type), .mem_size(mem_size),
        .state(state), .mem_err(mem_err), .exc_illegal(exc_illegal)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t o_fetch(input logic rdy);
        obs_t o = '0;
        o.st = 4'd0; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
        o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic obs_t o_decode();
        obs_t o = '0;
        o.st = 4'd1; o.alu_src_b = 2'b11;
        return o;
    endfunction
    function automatic obs_t o_mem_addr();
        obs_t o = '0;
        o.st = 4'd2; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic obs_t o_mem_rd(input logic [1:0] sz);
        obs_t o = '0;
        o.st = 4'd3; o.mem_read = 1'b1; o.iord = 1'b1; o.mem_size = sz;
        return o;
    endfunction
    function automatic obs_t o_mem_wb();
        obs_t o = '0;
        o.st = 4'd4; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_mem_wr(input logic [1:0] sz);
        obs_t o = '0;
        o.st = 4'd5; o.mem_write = 1'b1; o.iord = 1'b1; o.mem_size = sz;
        return o;
    endfunction
    function automatic obs_t o_exec_r();
        obs_t o = '0;
        o.st = 4'd6; o.alu_src_a = 1'b1; o.alu_op = 2'b10;
        return o;
    endfunction
    function automatic obs_t o_alu_wb();
        obs_t o = '0;
        o.st = 4'd7; o.reg_write = 1'b1; o.reg_dst = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_branch(input logic [1:0] bt);
        obs_t o = '0;
        o.st = 4'd8; o.alu_src_a = 1'b1; o.alu_op = 2'b01;
        o.pc_write_cond = 1'b1; o.pc_source = 2'b01; o.branch_type = bt;
        return o;
    endfunction
    function automatic obs_t o_jump();
        obs_t o = '0;
        o.st = 4'd9; o.pc_write = 1'b1; o.pc_source = 2'b10;
        return o;
    endfunction
    function automatic obs_t o_exec_i();
        obs_t o = '0;
        o.st = 4'd10; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b11;
        return o;
    endfunction
    function automatic obs_t o_imm_wb();
        obs_t o = '0;
        o.st = 4'd11; o.reg_write = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_trap();
        obs_t o = '0;
        o.st = 4'd12; o.pc_write = 1'b1; o.pc_source = 2'b11; o.exc_illegal = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_err();
        obs_t o = '0;
        o.st = 4'd15; o.mem_err = 1'b1;
        return o;
    endfunction

    // Drive one cycle of inputs just after the edge and queue what that cycle must show.
    task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic rdy, input obs_t exp);
        @(posedge clk);
        #1;
        rst       = r;
        instr     = ins;
        mem_ready = rdy;
        sb_q.push_back(exp);
    endtask

    task automatic checkOutput(input obs_t exp, input obs_t got);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL vec%0d state%0d: got %h required %h", vectors, exp.st, got, exp);
        end
    endtask

    // Monitor: mid-cycle, compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        obs_t got;
        if (sb_q.size() > 0) begin
            got.st = state; got.pc_write = pc_write; got.pc_write_cond = pc_write_cond;
            got.iord = iord; got.mem_read = mem_read; got.mem_write = mem_write;
            got.ir_write = ir_write; got.mem_to_reg = mem_to_reg; got.reg_dst = reg_dst;
            got.reg_write = reg_write; got.alu_src_a = alu_src_a; got.alu_src_b = alu_src_b;
            got.alu_op = alu_op; got.pc_source = pc_source; got.branch_type = branch_type;
            got.mem_size = mem_size; got.mem_err = mem_err; got.exc_illegal = exc_illegal;
            checkOutput(sb_q.pop_front(), got);
        end
    end

    // Directed instruction sequences.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        instr       = 32'h0;
        mem_ready   = 1'b0;

        // Reset, then lw with no waits: 0,1,2,3,4,0
        applyStimulus(1'b1, 32'h0, 1'b0, o_fetch(1'b0));
        applyStimulus(1'b0, LW, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, LW, 1'b1, o_decode());
        applyStimulus(1'b0, LW, 1'b1, o_mem_addr());
        applyStimulus(1'b0, LW, 1'b1, o_mem_rd(2'b00));
        applyStimulus(1'b0, LW, 1'b1, o_mem_wb());
        // add: 0,1,6,7
        applyStimulus(1'b0, ADD, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, ADD, 1'b1, o_decode());
        applyStimulus(1'b0, ADD, 1'b1, o_exec_r());
        applyStimulus(1'b0, ADD, 1'b1, o_alu_wb());
        // bne, beq, bgtz
        applyStimulus(1'b0, BNE, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, BNE, 1'b1, o_decode());
        applyStimulus(1'b0, BNE, 1'b1, o_branch(2'b01));
        applyStimulus(1'b0, BEQ, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, BEQ, 1'b1, o_decode());
        applyStimulus(1'b0, BEQ, 1'b1, o_branch(2'b00));
        applyStimulus(1'b0, BGTZ, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, BGTZ, 1'b1, o_decode());
        applyStimulus(1'b0, BGTZ, 1'b1, o_branch(2'b10));
        // j
        applyStimulus(1'b0, JMP, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, JMP, 1'b1, o_decode());
        applyStimulus(1'b0, JMP, 1'b1, o_jump());
        // addi
        applyStimulus(1'b0, ADDI, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, ADDI, 1'b1, o_decode());
        applyStimulus(1'b0, ADDI, 1'b1, o_exec_i());
        applyStimulus(1'b0, ADDI, 1'b1, o_imm_wb());
        // sb with three wait cycles in MEM_WR
        applyStimulus(1'b0, SB, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, SB, 1'b1, o_decode());
        applyStimulus(1'b0, SB, 1'b1, o_mem_addr());
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, SB, 1'b0, o_mem_wr(2'b10));
        applyStimulus(1'b0, SB, 1'b1, o_mem_wr(2'b10));
        // sw, no waits
        applyStimulus(1'b0, SW, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, SW, 1'b1, o_decode());
        applyStimulus(1'b0, SW, 1'b1, o_mem_addr());
        applyStimulus(1'b0, SW, 1'b1, o_mem_wr(2'b00));
        // lh with two wait cycles in MEM_RD
        applyStimulus(1'b0, LH, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, LH, 1'b1, o_decode());
        applyStimulus(1'b0, LH, 1'b1, o_mem_addr());
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, LH, 1'b0, o_mem_rd(2'b01));
        applyStimulus(1'b0, LH, 1'b1, o_mem_rd(2'b01));
        applyStimulus(1'b0, LH, 1'b1, o_mem_wb());
        // unknown opcode
        applyStimulus(1'b0, ILL, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, ILL, 1'b1, o_decode());
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        applyStimulus(1'b0, ADD, 1'b1, o_trap());
`endif
        // add abandoned by reset in EXEC_R
        applyStimulus(1'b0, ADD, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, ADD, 1'b1, o_decode());
        applyStimulus(1'b1, ADD, 1'b1, o_exec_r());
        // lw whose data arrives exactly when the counter reaches the limit
        applyStimulus(1'b0, LW, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, LW, 1'b1, o_decode());
        applyStimulus(1'b0, LW, 1'b1, o_mem_addr());
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, LW, 1'b0, o_mem_rd(2'b00));
        applyStimulus(1'b0, LW, 1'b1, o_mem_rd(2'b00));
        applyStimulus(1'b0, LW, 1'b0, o_mem_wb());
        // FETCH starved for 16 cycles: timeout into ERR
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, LW, 1'b0, o_fetch(1'b0));
        applyStimulus(1'b0, LW, 1'b1, o_err());
        applyStimulus(1'b0, LW, 1'b1, o_err());
        applyStimulus(1'b0, LW, 1'b0, o_err());
        applyStimulus(1'b1, LW, 1'b0, o_err());
        applyStimulus(1'b0, LW, 1'b1, o_fetch(1'b1));
        applyStimulus(1'b0, LW, 1'b1, o_decode());

        @(negedge clk);
        #1;
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
